multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Multi-cycle main controller for the 16-bit RISC core. It replaces the single-cycle combinational decoder with a FETCH/DECODE/EXEC/MEM/WB state machine. It adds a wait-state handshake on data memory, a bounded return-address stack tracker for nested CALL/RET, and an internal FOR-loop iteration counter. It sits between the instruction register and the datapath, and drives all PC, register-file, ALU-mux and memory strobes.

## Interface
- OPCODE_W, 4, opcode field width
- FUNC_W, 3, function field width
- ITER_W, 16, FOR iteration counter width
- RS_DEPTH, 4, return-stack depth (entries held in the datapath; this block tracks the pointer)
- SP_W, $clog2(RS_DEPTH+1), stack pointer width (derived)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  IR opcode; valid from DECODE onward
- func  in  FUNC_W  IR function field
- zero  in  1  ALU zero flag, sampled in EXEC
- iter_value  in  ITER_W  iteration count from Rt, sampled in FOR EXEC
- mem_ready  in  1  data memory completes the access this cycle
- state  out  3  0=FETCH 1=DECODE 2=EXEC 3=MEM 4=WB
- ir_write, pc_write  out  1  IR / PC load strobes
- pc_src  out  2  0=PC+1, 1=branch/loop target, 2=jump target, 3=return stack top
- rs_push, rs_pop  out  1  return-stack strobes
- rs_sp  out  SP_W  entries currently on the stack
- write_en, dest_reg, ext_op, write_src, alu_srcB  out  1  encodings are those of the existing decoder (dest_reg 0=Rd/1=Rt; write_src 1=ALU/0=memory; alu_srcB 1=RegB/0=imm; ext_op 1=signed)
- mem_r, mem_w  out  1  data memory strobes
- iter_active  out  1  a FOR loop is in progress
- iter_count  out  ITER_W  remaining iterations
- illegal  out  1  one-cycle pulse on an undefined or faulting instruction

## Operation
- Opcodes: 0 R-type, 1 J-type (func 0 JMP, 1 CALL, 2 RET), 2 ANDI, 3 ADDI, 4 LW, 5 SW, 6 BEQ, 7 BNE, 8 FOR. Everything else is illegal, as is J-type with func>2.
- Every instruction starts with FETCH: ir_write=1, pc_write=1, pc_src=0. Next state is DECODE.
- R, ANDI, ADDI: DECODE→EXEC→WB→FETCH. write_en=1 only in WB.
- LW: DECODE→EXEC→MEM→WB→FETCH. SW: DECODE→EXEC→MEM→FETCH.
- In MEM, mem_r (LW) or mem_w (SW) is held until mem_ready=1. The state stays MEM while mem_ready=0.
- BEQ/BNE: DECODE→EXEC→FETCH. EXEC asserts pc_write with pc_src=1 when taken (BEQ: zero=1, BNE: zero=0).
- JMP: in DECODE, pc_write=1 and pc_src=2, then FETCH.
- CALL: in DECODE, pc_write=1, pc_src=2, rs_push=1, and rs_sp increments. If rs_sp==RS_DEPTH, no push and no PC write occur, and illegal pulses.
- RET: in DECODE, pc_write=1, pc_src=3, rs_pop=1, and rs_sp decrements. If rs_sp==0, no pop and no PC write occur, and illegal pulses.
- FOR: DECODE→EXEC→FETCH.
  - In EXEC, next = iter_active ? iter_count−1 : iter_value−1.
  - If iter_active=0 and iter_value≤1: fall through and stay idle.
  - Else if next≠0: pc_write=1, pc_src=1, iter_count=next, iter_active=1.
  - Else: fall through, iter_count=0, iter_active=0.
  - Loops are not nested; an active counter is always reused.
- Illegal opcode: DECODE pulses illegal, asserts no write strobes, and returns to FETCH.
- ext_op, alu_srcB and dest_reg are driven from DECODE through WB according to opcode. They are 0 in FETCH. Don't-care values are driven as 0, never x.

## Timing
- On reset: state=FETCH, rs_sp=0, iter_count=0, iter_active=0.
- While reset is held, all strobes (ir_write, pc_write, write_en, mem_r, mem_w, rs_push, rs_pop, illegal) are 0. The first FETCH strobes appear in the cycle after reset deasserts.
- Reset during MEM drops mem_w/mem_r in the next cycle. A pending write is abandoned.
- Cycle counts with mem_ready=1:
  - R/ANDI/ADDI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ/BNE/FOR: 3 cycles
  - JMP/CALL/RET/illegal: 2 cycles
  - Each mem_ready=0 cycle in MEM adds one cycle.
- Outputs are combinational from state, opcode, func, zero and the registers. All registers update on the rising edge of clk.

## Test plan
- Reset held for 3 cycles, then released with opcode 0 → state=0 and all strobes 0 during reset; ir_write=1 in the first cycle after reset; WB (write_en=1) on cycle 4.
- LW with mem_ready low for 2 cycles → MEM lasts 3 cycles with mem_r=1 throughout; WB has write_src=0 and write_en=1; total 7 cycles.
- BEQ with zero=1, then BNE with zero=1 → first asserts pc_write with pc_src=1 in EXEC; second asserts no EXEC pc_write.
- Five CALLs with RS_DEPTH=4 → rs_sp counts 1,2,3,4; fifth CALL pulses illegal with no rs_push and rs_sp stays 4. Five RETs → rs_sp counts down to 0; fifth RET pulses illegal.
- FOR with iter_value=3 executed repeatedly → first two execute the loop branch (iter_count 2, then 1); third falls through with iter_active=0. A single FOR with iter_value=0 or 1 → never branches.
- Opcode 4'hF, and J-type with func=5 → illegal pulses in DECODE, no write strobes asserted, FETCH follows.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main controller for the 16-bit multi-cycle RISC core. It sequences each
// instruction through FETCH / DECODE / EXEC / MEM / WB and drives the PC,
// IR, register-file, ALU-mux and data-memory strobes for the datapath.
//
// The controller also:
//   - tracks the pointer of the return-address stack held in the datapath
//     (the entries themselves live in the datapath),
//   - holds the FOR-loop iteration counter, and
//   - stretches MEM with wait states until data memory reports ready.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   opcode       IR opcode, valid from DECODE onward
//   func         IR function field (selects JMP/CALL/RET for J-type)
//   zero         ALU zero flag, used by BEQ/BNE in EXEC
//   iter_value   loop count from Rt, used by FOR in EXEC
//   mem_ready    data memory completes the access this cycle
//   state        current state: 0=FETCH 1=DECODE 2=EXEC 3=MEM 4=WB
//   ir_write     load the instruction register
//   pc_write     load the program counter
//   pc_src       0=PC+1, 1=branch/loop target, 2=jump target, 3=stack top
//   rs_push      push PC+1 onto the return stack
//   rs_pop       pop the return stack
//   rs_sp        number of entries currently on the return stack
//   write_en     register-file write enable (WB only)
//   dest_reg     0=Rd, 1=Rt
//   ext_op       1=sign-extend immediate, 0=zero-extend
//   write_src    1=ALU result, 0=memory data
//   alu_srcB     1=register B, 0=immediate
//   mem_r        data memory read strobe
//   mem_w        data memory write strobe
//   iter_active  a FOR loop is in progress
//   iter_count   remaining loop iterations
//   illegal      one-cycle pulse on an undefined or faulting instruction
//
// All outputs are combinational from the state, the IR fields, the zero flag
// and the registers held here. Every register updates on the rising edge.
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int OPCODE_W = 4,
  parameter int FUNC_W   = 3,
  parameter int ITER_W   = 16,
  parameter int RS_DEPTH = 4,
  parameter int SP_W     = $clog2(RS_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic                zero,
  input  logic [ITER_W-1:0]   iter_value,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                rs_push,
  output logic                rs_pop,
  output logic [SP_W-1:0]     rs_sp,
  output logic                write_en,
  output logic                dest_reg,
  output logic                ext_op,
  output logic                write_src,
  output logic                alu_srcB,
  output logic                mem_r,
  output logic                mem_w,
  output logic                iter_active,
  output logic [ITER_W-1:0]   iter_count,
  output logic                illegal
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RET    = 2'd3
  } pc_src_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_JTYPE = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_FOR   = OPCODE_W'(8);

  localparam logic [FUNC_W-1:0] FN_JMP  = FUNC_W'(0);
  localparam logic [FUNC_W-1:0] FN_CALL = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] FN_RET  = FUNC_W'(2);

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(RS_DEPTH);

  // ---------------------------------------------------------------------------
  // State and bookkeeping registers
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [ITER_W-1:0]   iter_count_q, iter_count_d;
  logic                iter_active_q, iter_active_d;
  logic [ITER_W-1:0]   iter_next;

  // Datapath select fields decoded purely from the opcode.
  logic                fld_dest_reg, fld_ext_op, fld_write_src, fld_alu_srcB;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others; blocking here would create ordering
    // dependent races between the registers updated in this block.
    if (reset) begin
      state_q       <= S_FETCH;
      sp_q          <= '0;
      iter_count_q  <= '0;
      iter_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sp_q          <= sp_d;
      iter_count_q  <= iter_count_d;
      iter_active_q <= iter_active_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Opcode -> datapath select fields. Unused selects are driven to 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a
    // path that leaves one unassigned would infer a latch.
    fld_dest_reg  = 1'b0;
    fld_ext_op    = 1'b0;
    fld_write_src = 1'b0;
    fld_alu_srcB  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        fld_write_src = 1'b1;
        fld_alu_srcB  = 1'b1;
      end
      OP_ANDI: begin
        // Logical immediate is zero-extended.
        fld_dest_reg  = 1'b1;
        fld_write_src = 1'b1;
      end
      OP_ADDI: begin
        fld_dest_reg  = 1'b1;
        fld_ext_op    = 1'b1;
        fld_write_src = 1'b1;
      end
      OP_LW: begin
        fld_dest_reg  = 1'b1;
        fld_ext_op    = 1'b1;
      end
      OP_SW: begin
        fld_ext_op    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        // Compare two registers; the branch offset is signed.
        fld_ext_op    = 1'b1;
        fld_alu_srcB  = 1'b1;
      end
      OP_FOR: begin
        // Loop-back offset is signed.
        fld_ext_op    = 1'b1;
      end
      default: ;
    endcase
  end

  // Candidate new loop count: an active loop always reuses its own counter.
  always_comb begin
    iter_next = iter_active_q ? (iter_count_q - ITER_W'(1))
                              : (iter_value - ITER_W'(1));
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    iter_count_d  = iter_count_q;
    iter_active_d = iter_active_q;

    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_INC;
    rs_push   = 1'b0;
    rs_pop    = 1'b0;
    write_en  = 1'b0;
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        pc_src   = PC_INC;
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_RTYPE, OP_ANDI, OP_ADDI, OP_LW, OP_SW,
          OP_BEQ, OP_BNE, OP_FOR: begin
            state_d = S_EXEC;
          end
          OP_JTYPE: begin
            case (func)
              FN_JMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
              end
              FN_CALL: begin
                // A full stack faults instead of overwriting the oldest entry.
                if (sp_q == SP_FULL) begin
                  illegal = 1'b1;
                end else begin
                  pc_write = 1'b1;
                  pc_src   = PC_JUMP;
                  rs_push  = 1'b1;
                  sp_d     = sp_q + SP_W'(1);
                end
              end
              FN_RET: begin
                if (sp_q == '0) begin
                  illegal = 1'b1;
                end else begin
                  pc_write = 1'b1;
                  pc_src   = PC_RET;
                  rs_pop   = 1'b1;
                  sp_d     = sp_q - SP_W'(1);
                end
              end
              default: illegal = 1'b1;
            endcase
          end
          default: illegal = 1'b1;
        endcase
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_RTYPE, OP_ANDI, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:               state_d = S_MEM;
          OP_BEQ: begin
            if (zero) begin
              pc_write = 1'b1;
              pc_src   = PC_BRANCH;
            end
          end
          OP_BNE: begin
            if (!zero) begin
              pc_write = 1'b1;
              pc_src   = PC_BRANCH;
            end
          end
          OP_FOR: begin
            if (!iter_active_q && (iter_value <= ITER_W'(1))) begin
              // Zero or one iteration requested: body already ran once.
            end else if (iter_next != '0) begin
              pc_write      = 1'b1;
              pc_src        = PC_BRANCH;
              iter_count_d  = iter_next;
              iter_active_d = 1'b1;
            end else begin
              iter_count_d  = '0;
              iter_active_d = 1'b0;
            end
          end
          default: ;
        endcase
      end

      S_MEM: begin
        // Strobe is held every cycle until memory accepts the access.
        if (opcode == OP_LW) begin
          mem_r = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else begin
          mem_w = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
      end

      S_WB: begin
        write_en = 1'b1;
        state_d  = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // Nothing reaches the datapath while reset is held, including a write
    // that was waiting in MEM.
    if (reset) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src   = PC_INC;
      rs_push  = 1'b0;
      rs_pop   = 1'b0;
      write_en = 1'b0;
      mem_r    = 1'b0;
      mem_w    = 1'b0;
      illegal  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic fields_live;
  assign fields_live = !reset && (state_q != S_FETCH);

  assign state       = reset ? S_FETCH : state_q;
  assign dest_reg    = fields_live & fld_dest_reg;
  assign ext_op      = fields_live & fld_ext_op;
  assign write_src   = fields_live & fld_write_src;
  assign alu_srcB    = fields_live & fld_alu_srcB;
  assign rs_sp       = sp_q;
  assign iter_count  = iter_count_q;
  assign iter_active = iter_active_q;

endmodule
